// File: rtl/cache_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cache_ctrl_pkg
// Shared types and helpers for the two-way cache controller.
//   cache_state_t : controller FSM state encoding
//   way_t         : index of one cache way
//   NUM_WAYS      : number of ways (2)
//   hit_way_f     : way that hit, way 0 wins on a double match
//   victim_dirty_f: victim way holds valid modified data
// -----------------------------------------------------------------------------
package cache_ctrl_pkg;

    localparam int NUM_WAYS = 2;

    typedef logic [0:0] way_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COMPARE   = 2'd1,
        S_WRITEBACK = 2'd2,
        S_ALLOCATE  = 2'd3
    } cache_state_t;

    // Way 0 has priority if both qualified hit bits are set.
    function automatic way_t hit_way_f(input logic [NUM_WAYS-1:0] hit_vec);
        way_t way;
        if (hit_vec[0]) begin
            way = 1'b0;
        end else begin
            way = 1'b1;
        end
        return way;
    endfunction

    // A victim needs writing back only when it is both valid and dirty.
    function automatic logic victim_dirty_f(input logic [NUM_WAYS-1:0] valid_vec,
                                            input logic [NUM_WAYS-1:0] dirty_vec,
                                            input way_t                way);
        return valid_vec[way] & dirty_vec[way];
    endfunction

endpackage

// File: rtl/cache_ctrl_fsm_perf_ctr.sv
// -----------------------------------------------------------------------------
// cache_perf_ctr
// Saturating event counter: increments by one on each cycle inc is high and
// sticks at all ones.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears the count
//   inc   : count enable for this cycle
//   count : current count value
// -----------------------------------------------------------------------------
module cache_perf_ctr #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    // Next count: hold at all ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + CNT_WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {CNT_WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// cache_ctrl_fsm
// Control FSM of a two-way write-back, write-allocate cache.
// IDLE -> COMPARE on a CPU request; a hit responds in COMPARE, a miss goes
// through WRITEBACK (dirty victim) and/or ALLOCATE (line fill) and re-enters
// COMPARE, which then hits.
//
// Optional feature: define CACHE_PERF_CNT_EN to build saturating hit/miss
// counters; otherwise hit_count/miss_count are constant zero.
//
// Ports
//   clk, rst                    : clock, asynchronous active-high reset
//   mem_read, mem_write         : CPU request strobes (both high = write)
//   mem_resp                    : one-cycle CPU completion pulse
//   hit, valid_out, dirty_out   : per-way tag match / valid / dirty (comb read)
//   lru_out                     : LRU way index
//   pmem_read, pmem_write       : physical memory requests
//   pmem_resp                   : physical memory completion
//   tag_load, valid_load,
//   dirty_load, data_fill       : per-way array load enables
//   valid_in, dirty_in          : values written to valid / dirty arrays
//   data_we                     : per-way CPU write enable
//   lru_load, lru_in            : LRU array update
//   wb_addr_sel                 : selects the victim tag for the pmem address
//   hit_count, miss_count       : performance counters
// -----------------------------------------------------------------------------
import cache_ctrl_pkg::*;

module cache_ctrl_fsm #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    input  logic [1:0]           hit,
    input  logic [1:0]           valid_out,
    input  logic [1:0]           dirty_out,
    input  logic                 lru_out,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    output logic [1:0]           tag_load,
    output logic [1:0]           valid_load,
    output logic [1:0]           dirty_load,
    output logic [1:0]           data_fill,
    output logic                 valid_in,
    output logic                 dirty_in,
    output logic [1:0]           data_we,
    output logic                 lru_load,
    output logic                 lru_in,
    output logic                 wb_addr_sel,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    cache_state_t state_q;
    cache_state_t state_d;
    way_t         victim_q;
    way_t         victim_d;

    logic       req_s;
    logic       is_write_s;
    logic [1:0] hit_vec_s;
    logic       hit_any_s;
    way_t       hit_way_s;

    assign req_s      = mem_read | mem_write;
    assign is_write_s = mem_write;           // read+write together is a write
    assign hit_vec_s  = hit & valid_out;
    assign hit_any_s  = |hit_vec_s;
    assign hit_way_s  = hit_way_f(hit_vec_s);

    // State and victim registers. Reset returns to IDLE at once, which also
    // forces every decoded output low without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    // Next-state and output decode. Outputs are decoded from the current
    // state and the array read data, so a hit responds in the COMPARE cycle.
    always_comb begin
        state_d     = state_q;
        victim_d    = victim_q;
        mem_resp    = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        tag_load    = 2'b00;
        valid_load  = 2'b00;
        dirty_load  = 2'b00;
        data_fill   = 2'b00;
        valid_in    = 1'b0;
        dirty_in    = 1'b0;
        data_we     = 2'b00;
        lru_load    = 1'b0;
        lru_in      = 1'b0;
        wb_addr_sel = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    state_d = S_COMPARE;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_COMPARE: begin
                if (!req_s) begin
                    // Request withdrawn: abandon quietly.
                    state_d = S_IDLE;
                end else if (hit_any_s) begin
                    mem_resp = 1'b1;
                    lru_load = 1'b1;
                    lru_in   = ~hit_way_s;   // the other way becomes LRU
                    if (is_write_s) begin
                        data_we[hit_way_s]    = 1'b1;
                        dirty_load[hit_way_s] = 1'b1;
                        dirty_in              = 1'b1;
                    end else begin
                        dirty_in = 1'b0;
                    end
                    state_d = S_IDLE;
                end else begin
                    victim_d = lru_out;
                    if (victim_dirty_f(valid_out, dirty_out, lru_out)) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_ALLOCATE;
                    end
                end
            end

            S_WRITEBACK: begin
                pmem_write  = 1'b1;
                wb_addr_sel = 1'b1;
                if (pmem_resp) begin
                    state_d = S_ALLOCATE;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end

            S_ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    tag_load[victim_q]   = 1'b1;
                    valid_load[victim_q] = 1'b1;
                    dirty_load[victim_q] = 1'b1;
                    data_fill[victim_q]  = 1'b1;
                    valid_in             = 1'b1;
                    dirty_in             = 1'b0;
                    state_d              = S_COMPARE;
                end else begin
                    state_d = S_ALLOCATE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef CACHE_PERF_CNT_EN
    // Marks the COMPARE pass that follows a line fill, whose guaranteed hit
    // is not a genuine first-pass hit.
    logic refill_q;
    logic hit_inc_s;
    logic miss_inc_s;

    // Refill flag: high for exactly the COMPARE cycle entered from ALLOCATE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refill_q <= 1'b0;
        end else begin
            refill_q <= (state_q == S_ALLOCATE) && pmem_resp;
        end
    end

    assign hit_inc_s  = (state_q == S_COMPARE) && req_s && hit_any_s && !refill_q;
    assign miss_inc_s = (state_q == S_COMPARE) && req_s && !hit_any_s;

    cache_perf_ctr #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_hit_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc_s),
        .count (hit_count)
    );

    cache_perf_ctr #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_miss_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc_s),
        .count (miss_count)
    );
`else
    assign hit_count  = {CNT_WIDTH{1'b0}};
    assign miss_count = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl_fsm
// Directed self-checking bench for cache_ctrl_fsm. A second instance with
// CNT_WIDTH = 2 shares all inputs to observe counter saturation.
// -----------------------------------------------------------------------------
module tb_cache_ctrl_fsm;

`ifdef CACHE_PERF_CNT_EN
    localparam logic PERF_EN = 1'b1;
`else
    localparam logic PERF_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  hit;
    logic [1:0]  valid_out;
    logic [1:0]  dirty_out;
    logic        lru_out;
    logic        pmem_resp;

    logic        mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [1:0]  tag_load;
    logic [1:0]  valid_load;
    logic [1:0]  dirty_load;
    logic [1:0]  data_fill;
    logic        valid_in;
    logic        dirty_in;
    logic [1:0]  data_we;
    logic        lru_load;
    logic        lru_in;
    logic        wb_addr_sel;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    logic        s_mem_resp;
    logic        s_pmem_read;
    logic        s_pmem_write;
    logic [1:0]  s_tag_load;
    logic [1:0]  s_valid_load;
    logic [1:0]  s_dirty_load;
    logic [1:0]  s_data_fill;
    logic        s_valid_in;
    logic        s_dirty_in;
    logic [1:0]  s_data_we;
    logic        s_lru_load;
    logic        s_lru_in;
    logic        s_wb_addr_sel;
    logic [1:0]  s_hit_count;
    logic [1:0]  s_miss_count;

    logic [17:0] all_outs;
    assign all_outs = {mem_resp, pmem_read, pmem_write, tag_load, valid_load,
                       dirty_load, data_fill, valid_in, dirty_in, data_we,
                       lru_load, lru_in, wb_addr_sel};

    int checks   = 0;
    int failures = 0;
    int exp_hit  = 0;
    int exp_miss = 0;

    cache_ctrl_fsm dut (
        .clk (clk), .rst (rst), .mem_read (mem_read), .mem_write (mem_write),
        .mem_resp (mem_resp), .hit (hit), .valid_out (valid_out),
        .dirty_out (dirty_out), .lru_out (lru_out), .pmem_read (pmem_read),
        .pmem_write (pmem_write), .pmem_resp (pmem_resp), .tag_load (tag_load),
        .valid_load (valid_load), .dirty_load (dirty_load),
        .data_fill (data_fill), .valid_in (valid_in), .dirty_in (dirty_in),
        .data_we (data_we), .lru_load (lru_load), .lru_in (lru_in),
        .wb_addr_sel (wb_addr_sel), .hit_count (hit_count),
        .miss_count (miss_count)
    );

    cache_ctrl_fsm #(.CNT_WIDTH (2)) dut_sat (
        .clk (clk), .rst (rst), .mem_read (mem_read), .mem_write (mem_write),
        .mem_resp (s_mem_resp), .hit (hit), .valid_out (valid_out),
        .dirty_out (dirty_out), .lru_out (lru_out), .pmem_read (s_pmem_read),
        .pmem_write (s_pmem_write), .pmem_resp (pmem_resp),
        .tag_load (s_tag_load), .valid_load (s_valid_load),
        .dirty_load (s_dirty_load), .data_fill (s_data_fill),
        .valid_in (s_valid_in), .dirty_in (s_dirty_in), .data_we (s_data_we),
        .lru_load (s_lru_load), .lru_in (s_lru_in),
        .wb_addr_sel (s_wb_addr_sel), .hit_count (s_hit_count),
        .miss_count (s_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_counters(input string tag);
        int sat_hit;
        int sat_miss;
        sat_hit  = (exp_hit  > 3) ? 3 : exp_hit;
        sat_miss = (exp_miss > 3) ? 3 : exp_miss;
        chk({tag, "_hit_count"},  64'(hit_count),    PERF_EN ? 64'(exp_hit)  : 64'd0);
        chk({tag, "_miss_count"}, 64'(miss_count),   PERF_EN ? 64'(exp_miss) : 64'd0);
        chk({tag, "_sat_hit"},    64'(s_hit_count),  PERF_EN ? 64'(sat_hit)  : 64'd0);
        chk({tag, "_sat_miss"},   64'(s_miss_count), PERF_EN ? 64'(sat_miss) : 64'd0);
    endtask

    // One CPU hit starting from IDLE; checks latency and COMPARE outputs.
    task automatic cpu_hit(input string tag, input logic rd, input logic wr,
                           input logic [1:0] h, input logic [1:0] v,
                           input logic [1:0] exp_we, input logic exp_lru_in);
        mem_read = rd; mem_write = wr; hit = h; valid_out = v; dirty_out = 2'b00;
        #1;
        chk({tag, "_no_early_resp"}, 64'(mem_resp), 64'd0);
        tick();
        #1;
        chk({tag, "_mem_resp"},   64'(mem_resp),   64'd1);
        chk({tag, "_lru_load"},   64'(lru_load),   64'd1);
        chk({tag, "_lru_in"},     64'(lru_in),     64'(exp_lru_in));
        chk({tag, "_data_we"},    64'(data_we),    64'(exp_we));
        chk({tag, "_dirty_load"}, 64'(dirty_load), 64'(exp_we));
        chk({tag, "_dirty_in"},   64'(dirty_in),   64'(|exp_we));
        chk({tag, "_pmem"},       64'({pmem_read, pmem_write}), 64'd0);
        exp_hit++;
        tick();
        mem_read = 1'b0; mem_write = 1'b0;
        #1;
        chk({tag, "_idle_outs"}, 64'(all_outs), 64'd0);
    endtask

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; hit = 2'b00;
        valid_out = 2'b00; dirty_out = 2'b00; lru_out = 1'b0; pmem_resp = 1'b0;
        #3;
        chk("reset_outs", 64'(all_outs), 64'd0);
        chk_counters("reset");
        tick();
        rst = 1'b0;
        #1;
        chk("post_reset_outs", 64'(all_outs), 64'd0);

        // Hits: read way 1, write way 0, read+write double match, two more reads.
        cpu_hit("rd_hit",   1'b1, 1'b0, 2'b10, 2'b11, 2'b00, 1'b0);
        cpu_hit("wr_hit",   1'b0, 1'b1, 2'b01, 2'b01, 2'b01, 1'b1);
        cpu_hit("rw_dbl",   1'b1, 1'b1, 2'b11, 2'b11, 2'b01, 1'b1);
        chk_counters("three_hits");

        // Read miss, clean victim way 1, fill answered in the 5th cycle.
        mem_read = 1'b1; hit = 2'b00; valid_out = 2'b10; dirty_out = 2'b00; lru_out = 1'b1;
        tick();
        #1;
        chk("rd_miss_no_resp", 64'(all_outs), 64'd0);
        exp_miss++;
        tick();
        for (int i = 0; i < 5; i++) begin
            pmem_resp = (i == 4);
            #1;
            chk("rd_miss_pmem_read",  64'(pmem_read),  64'd1);
            chk("rd_miss_pmem_write", 64'(pmem_write), 64'd0);
            if (i < 4) begin
                chk("rd_miss_wait_loads", 64'({tag_load, valid_load, data_fill}), 64'd0);
            end else begin
                chk("rd_fill_tag_load",   64'(tag_load),   64'd2);
                chk("rd_fill_valid_load", 64'(valid_load), 64'd2);
                chk("rd_fill_data_fill",  64'(data_fill),  64'd2);
                chk("rd_fill_in",         64'({valid_in, dirty_in}), 64'd2);
            end
            tick();
        end
        pmem_resp = 1'b0; hit = 2'b10; valid_out = 2'b11;
        #1;
        chk("rd_refill_resp",   64'(mem_resp),  64'd1);
        chk("rd_refill_lru_in", 64'(lru_in),    64'd0);
        chk("rd_refill_pmem",   64'(pmem_read), 64'd0);
        tick();
        mem_read = 1'b0;
        #1;
        chk_counters("after_rd_miss");

        // Write miss, dirty victim way 0: writeback (3 cycles) then fill (2 cycles).
        mem_write = 1'b1; hit = 2'b00; valid_out = 2'b01; dirty_out = 2'b01; lru_out = 1'b0;
        tick();
        #1;
        chk("wr_miss_no_resp", 64'(mem_resp), 64'd0);
        exp_miss++;
        tick();
        for (int i = 0; i < 3; i++) begin
            pmem_resp = (i == 2);
            #1;
            chk("wb_pmem", 64'({pmem_write, pmem_read, wb_addr_sel}), 64'd5);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            pmem_resp = (i == 1);
            #1;
            chk("wr_alloc_pmem", 64'({pmem_write, pmem_read, wb_addr_sel}), 64'd2);
            tick();
            if (i == 0) begin
                chk("wr_alloc_wait_loads", 64'(tag_load), 64'd0);
            end else begin
                chk("wr_alloc_done", 64'(pmem_read), 64'd0);
            end
        end
        // Re-check fill outputs with a fresh pass is not possible; check the re-COMPARE.
        pmem_resp = 1'b0; hit = 2'b01; valid_out = 2'b01; dirty_out = 2'b00;
        #1;
        chk("wr_refill_resp",    64'(mem_resp),   64'd1);
        chk("wr_refill_data_we", 64'(data_we),    64'd1);
        chk("wr_refill_dirty",   64'({dirty_load, dirty_in}), 64'd3);
        tick();
        mem_write = 1'b0;
        #1;
        chk_counters("after_wr_miss");

        // Request withdrawn in COMPARE; pmem_resp ignored in IDLE.
        mem_read = 1'b1; hit = 2'b00; valid_out = 2'b00; dirty_out = 2'b00; lru_out = 1'b1;
        tick();
        mem_read = 1'b0;
        pmem_resp = 1'b1;
        #1;
        chk("drop_compare_outs", 64'(all_outs), 64'd0);
        tick();
        #1;
        chk("drop_back_idle", 64'(all_outs), 64'd0);
        tick();
        pmem_resp = 1'b0;
        #1;
        chk("idle_ignores_pmem_resp", 64'(all_outs), 64'd0);
        chk_counters("after_drop");

        // Two more hits take the 2-bit counter past saturation (5 hits).
        cpu_hit("rd_hit4", 1'b1, 1'b0, 2'b01, 2'b11, 2'b00, 1'b1);
        cpu_hit("rd_hit5", 1'b1, 1'b0, 2'b11, 2'b10, 2'b00, 1'b0);
        chk_counters("five_hits");

        // Reset in the middle of ALLOCATE.
        mem_read = 1'b1; hit = 2'b00; valid_out = 2'b00; dirty_out = 2'b00; lru_out = 1'b1;
        tick();
        exp_miss++;
        tick();
        #1;
        chk("pre_rst_pmem_read", 64'(pmem_read), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_outs", 64'(all_outs), 64'd0);
        exp_hit = 0; exp_miss = 0;
        chk_counters("async_rst");
        mem_read = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        #1;
        chk("after_rst_idle", 64'(all_outs), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
